// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - op codes (mdu_op_e) as driven on mdu.op
//   - default busy cycle counts for multiply- and divide-class ops
//   - FSM state encoding for the mdu sequencer
//   - mdu_is_md(): stage-D helper. Stall D when it holds an MD-class op
//     while E has start asserted or mdu.busy is high.
// Optional feature: `MDU_MADD_EN makes op codes 6/7 (MADD/MADDU) MD-class.
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_MADD  = 3'd6,
        OP_MADDU = 3'd7
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    localparam int unsigned MDU_MULT_CYCLES_DEF = 5;
    localparam int unsigned MDU_DIV_CYCLES_DEF  = 10;

    function automatic logic mdu_is_md(input logic [2:0] op);
`ifdef MDU_MADD_EN
        return 1'b1;
`else
        return (op <= 3'd5);
`endif
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// mdu_calc: combinational datapath of the multiply/divide unit.
// Ports:
//   op     in  3   operation code (mdu_op_e)
//   rs,rt  in  32  operands from stage E
//   hi_in  in  32  current architectural HI
//   lo_in  in  32  current architectural LO
//   res_hi out 32  HI value the op would commit
//   res_lo out 32  LO value the op would commit
// Ops that do not produce a result (MTHI/MTLO/undefined) return {hi_in,lo_in}.
// Optional feature: `MDU_MADD_EN adds the MADD/MADDU accumulate path.
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic [31:0] hi_in,
    input  logic [31:0] lo_in,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo
);

    logic        mul_signed;
    logic        div_signed;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] prod;

    logic [31:0] dvd_mag;
    logic [31:0] dvs_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        div_zero;

    assign mul_signed = (op == OP_MULT) || (op == OP_MADD);
    assign div_signed = (op == OP_DIV);

    // Low 64 bits of the extended product equal the signed product mod 2^64.
    assign mul_a = mul_signed ? {{32{rs[31]}}, rs} : {32'd0, rs};
    assign mul_b = mul_signed ? {{32{rt[31]}}, rt} : {32'd0, rt};
    assign prod  = mul_a * mul_b;

    // Signed division runs on magnitudes and fixes signs afterwards; this
    // also yields 0x80000000 / -1 = 0x80000000 rem 0 without a special case.
    assign dvd_mag  = (div_signed && rs[31]) ? (~rs + 32'd1) : rs;
    assign dvs_mag  = (div_signed && rt[31]) ? (~rt + 32'd1) : rt;
    assign div_zero = (rt == '0);
    assign q_mag    = div_zero ? '0 : (dvd_mag / dvs_mag);
    assign r_mag    = div_zero ? '0 : (dvd_mag % dvs_mag);
    assign quot     = (div_signed && (rs[31] ^ rt[31])) ? (~q_mag + 32'd1) : q_mag;
    assign rem      = (div_signed && rs[31]) ? (~r_mag + 32'd1) : r_mag;

    always_comb begin
        res_hi = hi_in;
        res_lo = lo_in;
        case (op)
            OP_MULT, OP_MULTU: begin
                res_hi = prod[63:32];
                res_lo = prod[31:0];
            end
            OP_DIV, OP_DIVU: begin
                if (!div_zero) begin
                    res_hi = rem;
                    res_lo = quot;
                end
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU: begin
                {res_hi, res_lo} = {hi_in, lo_in} + prod;
            end
`endif
            default: begin
                res_hi = hi_in;
                res_lo = lo_in;
            end
        endcase
    end

endmodule

// File: rtl/mdu.sv
// mdu: multiply/divide unit in stage E. Holds architectural HI/LO and runs
// multiply/divide-class ops as fixed-latency multi-cycle operations.
// Parameters:
//   MULT_CYCLES  busy cycles for MULT/MULTU/MADD/MADDU (1..15)
//   DIV_CYCLES   busy cycles for DIV/DIVU (1..15)
// Ports:
//   clk    in  1   clock
//   reset  in  1   asynchronous active-low reset
//   start  in  1   op valid in stage E this cycle
//   op     in  3   operation code (mdu_pkg::mdu_op_e)
//   rs,rt  in  32  forwarded operands
//   busy   out 1   multi-cycle op in flight (registered)
//   hi,lo  out 32  architectural HI/LO (registered)
// Optional feature: `MDU_MADD_EN enables MADD/MADDU; otherwise ops 6/7 are
// ignored like any undefined op.
module mdu
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

    mdu_state_e  state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic [31:0] p_hi, p_hi_nx;
    logic [31:0] p_lo, p_lo_nx;
    logic [31:0] hi_nx, lo_nx;
    logic [31:0] res_hi, res_lo;
    logic        is_mul, is_div;

    mdu_calc u_calc (
        .op     (op),
        .rs     (rs),
        .rt     (rt),
        .hi_in  (hi),
        .lo_in  (lo),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

`ifdef MDU_MADD_EN
    assign is_mul = (op == OP_MULT) || (op == OP_MULTU) ||
                    (op == OP_MADD) || (op == OP_MADDU);
`else
    assign is_mul = (op == OP_MULT) || (op == OP_MULTU);
`endif
    assign is_div = (op == OP_DIV) || (op == OP_DIVU);

    assign busy = (state == ST_RUN);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        p_hi_nx  = p_hi;
        p_lo_nx  = p_lo;
        hi_nx    = hi;
        lo_nx    = lo;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (is_mul || is_div) begin
                        // Result is captured at issue; HI/LO cannot change
                        // while RUN, so a zero divisor commits the old values.
                        p_hi_nx  = res_hi;
                        p_lo_nx  = res_lo;
                        cnt_nx   = is_div ? DIV_N : MULT_N;
                        state_nx = ST_RUN;
                    end else if (op == OP_MTHI) begin
                        hi_nx = rs;
                    end else if (op == OP_MTLO) begin
                        lo_nx = rs;
                    end
                end
            end
            ST_RUN: begin
                if (cnt == 4'd1) begin
                    hi_nx    = p_hi;
                    lo_nx    = p_lo;
                    cnt_nx   = '0;
                    state_nx = ST_IDLE;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            p_hi  <= '0;
            p_lo  <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            p_hi  <= p_hi_nx;
            p_lo  <= p_lo_nx;
            hi    <= hi_nx;
            lo    <= lo_nx;
        end
    end

endmodule

// File: tb/tb_mdu.sv
module tb_mdu;
  import mdu_pkg::*;

  localparam int NM = 5;
  localparam int ND = 10;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  mdu #(
    .MULT_CYCLES (NM),
    .DIV_CYCLES  (ND)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .start (start),
    .op    (op),
    .rs    (rs),
    .rt    (rt),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  typedef struct {
    int          cyc;
    string       name;
    logic        chk;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   total  = 0;
  int   passed = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      total = total + 1;
      if (e.cyc == cyc && busy === e.busy &&
          (!e.chk || (hi === e.hi && lo === e.lo)))
        passed = passed + 1;
      else
        $display("FAIL %s @cyc %0d (stamped %0d): busy=%b hi=%h lo=%h, expected busy=%b hi=%h lo=%h%s",
                 e.name, cyc, e.cyc, busy, hi, lo, e.busy, e.hi, e.lo,
                 e.chk ? "" : " (hi/lo not checked)");
    end
  end

  task automatic push(input int c, input string n, input logic ck, input logic b,
                      input logic [31:0] h, input logic [31:0] l);
    exp_t e;
    e.cyc = c; e.name = n; e.chk = ck; e.busy = b; e.hi = h; e.lo = l;
    sb.push_back(e);
  endtask

  task automatic issue(input string name, input logic [2:0] o,
                       input logic [31:0] a, input logic [31:0] b, input int n,
                       input logic [31:0] eh, input logic [31:0] el, input int inj);
    int t0;
    t0 = cyc + 1;
    for (int unsigned k = 0; k < n; k++) push(t0 + int'(k), {name, "_busy"}, 1'b0, 1'b1, '0, '0);
    push(t0 + n, name, 1'b1, 1'b0, eh, el);
    start = 1'b1; op = o; rs = a; rt = b;
    @(negedge clk);
    start = 1'b0;
    for (int unsigned k = 1; k <= n; k++) begin
      if (int'(k) == inj) begin
        start = 1'b1; op = OP_MTHI; rs = 32'h0000_1234;
      end
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  initial begin
    int t0;
    rst_n = 1'b0; start = 1'b0; op = '0; rs = '0; rt = '0;
    @(negedge clk);
    push(cyc + 1, "reset0", 1'b1, 1'b0, '0, '0);
    push(cyc + 2, "reset1", 1'b1, 1'b0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    issue("mult",     OP_MULT,  32'hFFFF_FFFF, 32'd2, NM, 32'hFFFF_FFFF, 32'hFFFF_FFFE, -1);
    total = total + 1;
    if (!busy && hi === 32'hFFFF_FFFF && lo === 32'hFFFF_FFFE) passed = passed + 1;
    else $display("FAIL direct mult: busy=%b hi=%h lo=%h", busy, hi, lo);

    issue("multu",    OP_MULTU, 32'hFFFF_FFFF, 32'd2, NM, 32'h0000_0001, 32'hFFFF_FFFE, -1);
    total = total + 1;
    if (!busy && hi === 32'h0000_0001 && lo === 32'hFFFF_FFFE) passed = passed + 1;
    else $display("FAIL direct multu: busy=%b hi=%h lo=%h", busy, hi, lo);

    issue("div_m7_2", OP_DIV,   32'hFFFF_FFF9, 32'd2, ND, 32'hFFFF_FFFF, 32'hFFFF_FFFD, -1);
    total = total + 1;
    if (!busy && hi === 32'hFFFF_FFFF && lo === 32'hFFFF_FFFD) passed = passed + 1;
    else $display("FAIL direct div: busy=%b hi=%h lo=%h", busy, hi, lo);

    issue("divu_z",   OP_DIVU,  32'd7,         32'd0, ND, 32'hFFFF_FFFF, 32'hFFFF_FFFD, -1);
    total = total + 1;
    if (!busy && hi === 32'hFFFF_FFFF && lo === 32'hFFFF_FFFD) passed = passed + 1;
    else $display("FAIL direct divu_z: busy=%b hi=%h lo=%h", busy, hi, lo);

    issue("div_ovf",  OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, ND, 32'h0000_0000, 32'h8000_0000, -1);
    issue("div_7_m2", OP_DIV,   32'd7, 32'hFFFF_FFFE, ND, 32'h0000_0001, 32'hFFFF_FFFD, 3);
    issue("mtlo_b2b", OP_MTLO,  32'h0000_ABCD, 32'd0, 0, 32'h0000_0001, 32'h0000_ABCD, -1);
    total = total + 1;
    if (!busy && hi === 32'h0000_0001 && lo === 32'h0000_ABCD) passed = passed + 1;
    else $display("FAIL direct mtlo_b2b: busy=%b hi=%h lo=%h", busy, hi, lo);

    issue("mthi",     OP_MTHI,  32'h0000_0055, 32'd0, 0, 32'h0000_0055, 32'h0000_ABCD, -1);
    issue("mult_neg", OP_MULT,  32'hFFFF_FFFD, 32'hFFFF_FFFB, NM, 32'h0000_0000, 32'h0000_000F, -1);
    issue("mtlo2",    OP_MTLO,  32'h0000_ABCD, 32'd0, 0, 32'h0000_0000, 32'h0000_ABCD, -1);
    issue("mthi2",    OP_MTHI,  32'h0000_0055, 32'd0, 0, 32'h0000_0055, 32'h0000_ABCD, -1);
`ifndef MDU_MADD_EN
    issue("undef6",   3'd6,     32'd5, 32'd5, 0, 32'h0000_0055, 32'h0000_ABCD, -1);
    issue("undef7",   3'd7,     32'd5, 32'd5, 0, 32'h0000_0055, 32'h0000_ABCD, -1);
`endif

    t0 = cyc + 1;
    for (int unsigned k = 0; k < 3; k++) push(t0 + int'(k), "abort_busy", 1'b0, 1'b1, '0, '0);
    for (int unsigned k = 3; k <= 12; k++) push(t0 + int'(k), "abort", 1'b1, 1'b0, '0, '0);
    start = 1'b1; op = OP_DIV; rs = 32'd100; rt = 32'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    total = total + 1;
    if (!busy && hi === 32'h0 && lo === 32'h0) passed = passed + 1;
    else $display("FAIL direct abort: busy=%b hi=%h lo=%h", busy, hi, lo);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);

`ifdef MDU_MADD_EN
    issue("madd_mtlo", OP_MTLO,  32'hFFFF_FFFF, 32'd0, 0, 32'h0000_0000, 32'hFFFF_FFFF, -1);
    issue("maddu",     OP_MADDU, 32'd1, 32'd1, NM, 32'h0000_0001, 32'h0000_0000, -1);
    issue("madd_neg",  OP_MADD,  32'hFFFF_FFFF, 32'd1, NM, 32'h0000_0000, 32'hFFFF_FFFF, -1);
`endif

    repeat (3) @(negedge clk);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      total = total + 1;
      $display("FAIL %s: expectation for cyc %0d never compared (now cyc %0d)", e.name, e.cyc, cyc);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit for the five-stage core, sitting in stage E next to the ALU and consuming the forwarded `rs`/`rt` operands of that stage. It executes MULT/MULTU/DIV/DIVU as fixed-latency multi-cycle operations, holds the architectural HI/LO registers, and raises `busy` so stage-D hazard logic can stall any later multiply/divide-class instruction. MTHI/MTLO write HI/LO in one cycle; MFHI/MFLO read the `hi`/`lo` outputs combinationally.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for MULT/MULTU (and MADD/MADDU), 1..15.
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU, 1..15.

- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request; the op is valid in stage E this cycle.
- `op` in 3: operation code from the shared package.
- `rs` in 32: forwarded rs operand from stage E.
- `rt` in 32: forwarded rt operand from stage E.
- `busy` out 1: a multi-cycle operation is in flight.
- `hi` out 32: architectural HI.
- `lo` out 32: architectural LO.

## Operation
- Op codes: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5, MADD=6, MADDU=7.
- There are two states, IDLE and RUN.
- In IDLE, `start` with a MULT-class or DIV-class op does the following:
  - Computes the result into pending registers `p_hi`/`p_lo`.
  - Loads the down-counter with MULT_CYCLES or DIV_CYCLES.
  - Moves to RUN.
- In RUN, the counter decrements each cycle. When it reaches 1, the next edge commits `p_hi`/`p_lo` to `hi`/`lo` and returns the unit to IDLE.
- `busy` is 1 exactly when the state is RUN.
- MTHI/MTLO in IDLE write `rs` to `hi`/`lo` at the same edge. They do not enter RUN.
- Any `start` while in RUN is ignored. The core must stall and never issue one.
- MULT: signed 32×32 to 64; HI gets the upper word, LO the lower word. MULTU is the unsigned version.
- DIV: signed. LO gets the quotient, truncated toward zero. HI gets the remainder, which takes the sign of the dividend. DIVU is the unsigned version.
- Division by zero: HI/LO are unchanged at commit. The full busy period still elapses.
- 0x80000000 / -1 (signed): LO=0x80000000, HI=0.
- An undefined op with `start`: ignored.
- Reset mid-operation aborts the operation: state IDLE, counter 0, `hi`=`lo`=0, pending registers cleared.

## Timing
- Reset values: `busy`=0, `hi`=0, `lo`=0.
- `start` is sampled at edge T0. `busy`=1 from T0 through the cycle before edge T0+N, where N is MULT_CYCLES or DIV_CYCLES.
- `hi`/`lo` take the new value at edge T0+N, and `busy`=0 in that same cycle.
- A new `start` is accepted at edge T0+N (back-to-back issue).
- MTHI/MTLO: `hi`/`lo` are visible in the cycle after the edge.
- `hi`/`lo` are registered outputs with no combinational path from `rs`/`rt`.
- `busy` is registered.

## Configuration
- `MDU_MADD_EN` defined: MADD/MADDU are accepted. The 64-bit product (signed or unsigned) is added to {HI,LO} as sampled at T0, with wrap modulo 2^64. They use MULT_CYCLES.
- Not defined: op codes 6/7 are treated as undefined and ignored. No accumulate adder is synthesized.

## Structure
- Package `mdu_pkg` holds:
  - the op code constants;
  - default cycle counts;
  - a `mdu_is_md(op)` helper for the stage-D stall logic, which stalls when D holds an MD-class instruction and E holds `start` or `busy` is 1.
- One sub-module: `mdu_calc`, combinational. It produces the 64-bit {hi,lo} result from `op`, `rs`, `rt`, and the current `hi`/`lo`.
- Sequencing stays in `mdu`.

## Test plan
- Reset and MULT: release reset, then MULT rs=0xFFFFFFFF, rt=2. Expect `busy` high for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- MULTU: rs=0xFFFFFFFF, rt=2. Expect hi=1, lo=0xFFFFFFFE at T0+5.
- DIV: rs=-7, rt=2. Expect lo=0xFFFFFFFD, hi=0xFFFFFFFF at T0+10. Then DIVU with rs=7, rt=0. Expect hi/lo unchanged and busy for 10 cycles.
- Ignored start and back-to-back issue: `start`+MTHI rs=0x1234 during RUN is ignored. MTLO rs=0xABCD issued at T0+N sets lo=0xABCD in the next cycle.
- Abort: reset asserted at T0+3 of a DIV. Expect `busy`=0 and hi=lo=0 immediately; no commit follows.
- With `MDU_MADD_EN`: hi=0, lo=0xFFFFFFFF, then MADDU rs=1, rt=1. Expect hi=1, lo=0 after 5 cycles.
